// File: rtl/bias_fetch_ctrl_if.sv
// Bias fetch controller bundle: command/status, ROM read port and the
// outgoing bias stream. clk and reset_n stay plain ports on the controller.
interface bias_fetch_ctrl_if #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 240,
   parameter int MAX_CH = 64
);
   // Command and status
   logic                        start;
   logic [$clog2(DEPTH)-1:0]    base_addr;
   logic [$clog2(MAX_CH+1)-1:0] num_ch;
   logic                        busy;
   logic                        done;
   logic                        err;
   // ROM read port (data returns the cycle after the strobe)
   logic                        rom_read_enable;
   logic [$clog2(DEPTH)-1:0]    rom_addr;
   logic [WIDTH-1:0]            rom_bias_out;
   // Bias stream
   logic                        bias_valid;
   logic                        bias_ready;
   logic [WIDTH-1:0]            bias_data;
   logic [$clog2(MAX_CH)-1:0]   bias_idx;
   // Debug view of the controller state
   logic [1:0]                  fsm_state;

   modport master (
      input  start, base_addr, num_ch, rom_bias_out, bias_ready,
      output busy, done, err, rom_read_enable, rom_addr,
             bias_valid, bias_data, bias_idx, fsm_state
   );

   modport slave (
      output start, base_addr, num_ch, rom_bias_out, bias_ready,
      input  busy, done, err, rom_read_enable, rom_addr,
             bias_valid, bias_data, bias_idx, fsm_state
   );
endinterface

// File: rtl/bias_fetch_ctrl.sv
// Bias fetch controller: reads num_ch consecutive bias words from a
// one-cycle-latency ROM starting at base_addr and streams them out in
// channel order through a 2-entry FIFO.
//
// Stream handshake: bias_valid/bias_data/bias_idx come from the FIFO head.
// A word moves when bias_valid and bias_ready are both high at a rising
// clk edge; while bias_valid is high and bias_ready low the head is held
// unchanged. bias_valid never depends on bias_ready.
module bias_fetch_ctrl #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 240,
   parameter int MAX_CH = 64
) (
   input logic               clk,
   input logic               reset_n,
   bias_fetch_ctrl_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MAX_CH + 1);
   localparam int IW = $clog2(MAX_CH);
   localparam int SW = ((AW > CW) ? AW : CW) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic [AW-1:0]    base_q;
   logic [CW-1:0]    num_q;
   logic [CW-1:0]    issued_q;
   logic [CW-1:0]    xfer_q;
   logic [AW-1:0]    last_addr_q;
   logic             rd_inflight_q;
   logic [IW-1:0]    rd_tag_q;
   logic [WIDTH-1:0] fifo_data_q [2];
   logic [IW-1:0]    fifo_idx_q  [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   logic             push;
   logic             pop;
   logic [2:0]       outstanding;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic             last_xfer;
   logic [SW-1:0]    req_end;
   logic             range_err;

   // Read credit, read address and range check. The credit counts the word
   // in flight plus FIFO occupancy net of this cycle's pop, so a full-rate
   // stream keeps issuing while a stalled stream can never overflow 2 slots.
   always_comb begin
      push        = rd_inflight_q;
      pop         = (count_q != 2'd0) && bus.bias_ready;
      outstanding = {1'b0, count_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
      rd_en       = (state_q == S_FETCH) && (issued_q < num_q) && (outstanding < 3'd2);
      rd_addr     = base_q + AW'(issued_q);
      last_xfer   = pop && ((xfer_q + CW'(1)) == num_q);
      req_end     = SW'(bus.base_addr) + SW'(bus.num_ch);
      range_err   = req_end > SW'(DEPTH);
   end

   // Control FSM with its counters and registered busy/done/err.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         base_q   <= '0;
         num_q    <= '0;
         issued_q <= '0;
         xfer_q   <= '0;
      end else begin
         if (pop)   xfer_q   <= xfer_q + CW'(1);
         if (rd_en) issued_q <= issued_q + CW'(1);
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  base_q   <= bus.base_addr;
                  num_q    <= bus.num_ch;
                  err_q    <= 1'b0;
                  issued_q <= '0;
                  xfer_q   <= '0;
                  busy_q   <= 1'b1;
                  if (bus.num_ch == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (range_err) begin
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (rd_en && ((issued_q + CW'(1)) == num_q)) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (last_xfer) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // ROM return tracking, held read address and the 2-entry output FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_inflight_q  <= 1'b0;
         rd_tag_q       <= '0;
         last_addr_q    <= '0;
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_idx_q[0]  <= '0;
         fifo_idx_q[1]  <= '0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         count_q        <= 2'd0;
      end else begin
         rd_inflight_q <= rd_en;
         rd_tag_q      <= issued_q[IW-1:0];
         if (rd_en) last_addr_q <= rd_addr;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.rom_bias_out;
            fifo_idx_q[wr_ptr_q]  <= rd_tag_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.err             = err_q;
   assign bus.rom_read_enable = rd_en;
   assign bus.rom_addr        = rd_en ? rd_addr : last_addr_q;
   assign bus.bias_valid      = (count_q != 2'd0);
   assign bus.bias_data       = fifo_data_q[rd_ptr_q];
   assign bus.bias_idx        = fifo_idx_q[rd_ptr_q];
   assign bus.fsm_state       = state_q;
endmodule

// File: doc/bias_fetch_ctrl.md
BIAS_FETCH_CTRL -- requirements
Module: bias_fetch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bias word width in bits.
REQ-002 SHALL have parameter DEPTH, default 240, bias ROM entry count.
REQ-003 SHALL have parameter MAX_CH, default 64, max channels per fetch.
REQ-004 SHALL have port clk, input, 1: single clock, all state on posedge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request a fetch, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, $clog2(DEPTH): ROM address of channel 0 for the layer.
REQ-008 SHALL have port num_ch, input, $clog2(MAX_CH+1): number of biases to fetch.
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a fetch ends.
REQ-011 SHALL have port err, output, 1: sticky range error, cleared by the next accepted start.
REQ-012 SHALL have port rom_read_enable, output, 1: ROM read strobe.
REQ-013 SHALL have port rom_addr, output, $clog2(DEPTH): ROM read address.
REQ-014 SHALL have port rom_bias_out, input, WIDTH: ROM data, valid the cycle after the strobe.
REQ-015 SHALL have port bias_valid, output, 1: bias_data/bias_idx are valid.
REQ-016 SHALL have port bias_ready, input, 1: consumer accepts this cycle.
REQ-017 SHALL have port bias_data, output, WIDTH: bias word.
REQ-018 SHALL have port bias_idx, output, $clog2(MAX_CH): channel index of bias_data.

Function
REQ-019 SHALL implement the states IDLE, FETCH, DRAIN and DONE.
REQ-020 IDLE: when start=1 it SHALL latch base_addr and num_ch, clear err, and reset both counters to 0.
REQ-021 IDLE+start with num_ch=0 SHALL go to DONE with no ROM read.
REQ-022 IDLE+start with base_addr+num_ch>DEPTH (unsigned, widened) SHALL set err and go to DONE with no ROM read.
REQ-023 Otherwise IDLE+start SHALL go to FETCH.
REQ-024 FETCH: rom_read_enable SHALL be 1 only if issued<num_ch and (in-flight reads + FIFO occupancy)<2.
REQ-025 Each read SHALL drive rom_addr=base_addr+issued, and issued SHALL increment.
REQ-026 rom_read_enable SHALL be 0 otherwise.
REQ-027 rom_addr SHALL hold its last value when rom_read_enable is 0.
REQ-028 A read issued in cycle t SHALL push rom_bias_out in cycle t+1, tagged with its channel index, into a 2-entry FIFO.
REQ-029 rom_bias_out SHALL be ignored in cycles with no read in flight, because the ROM drives 0 then.
REQ-030 FIFO head SHALL drive bias_valid/bias_data/bias_idx.
REQ-031 A transfer SHALL occur when bias_valid and bias_ready are both 1.
REQ-032 bias_data and bias_idx SHALL hold stable while bias_valid=1 and bias_ready=0.
REQ-033 Push and pop in the same cycle SHALL be legal at any occupancy; the FIFO SHALL never overflow, by REQ-024.
REQ-034 Outputs SHALL appear in strictly ascending bias_idx 0..num_ch-1, no gaps, no duplicates.
REQ-035 FETCH SHALL go to DRAIN when issued reaches num_ch.
REQ-036 DRAIN SHALL go to DONE in the cycle after the last transfer (count of transfers = num_ch).
REQ-037 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-038 start SHALL be ignored while busy=1.
REQ-039 A new start SHALL be accepted in the cycle after done.
REQ-040 With bias_ready held 1, throughput SHALL be 1 bias/cycle.
REQ-041 With bias_ready held 1, the first bias_valid SHALL occur 2 cycles after start is sampled.
REQ-042 Address arithmetic SHALL never wrap; REQ-022 guarantees base_addr+issued<DEPTH.

Reset
REQ-043 reset_n=0 SHALL immediately force IDLE and clear the counters and FIFO.
REQ-044 reset_n=0 SHALL drive busy, done, err, rom_read_enable, bias_valid, rom_addr, bias_data and bias_idx to 0.
REQ-045 Reset mid-fetch SHALL abort the fetch with no done pulse; the in-flight ROM word SHALL be discarded.
REQ-046 After reset_n rises, the block SHALL accept start on the first clk edge.

Verification
REQ-047 base_addr=10, num_ch=4, ready=1 -> reads at addrs 10..13 on consecutive cycles; bias_idx 0..3 = rom[10..13] on 4 consecutive cycles; single done pulse.
REQ-048 base_addr=0, num_ch=8, ready toggling 1,0,0,1,... -> no loss or duplication; at most 2 outstanding; data held stable while stalled; done after idx 7.
REQ-049 base_addr=236, num_ch=4 -> normal completion, last addr 239, err=0.
REQ-050 base_addr=237, num_ch=4 -> err=1, done pulse, zero ROM reads, busy high for 1 cycle only.
REQ-051 num_ch=0 -> done pulse, no bias_valid; start pulsed during busy -> ignored, no second done.
REQ-052 reset_n low for 1 cycle after 2 of 6 biases transferred -> all outputs 0, no done; next start with base_addr=20, num_ch=2 -> completes normally.
